// File: rtl/conv_datapath.sv
// conv_datapath: convolution MAC datapath for the accelerator convolver.
//
// A shift-register window of KERNEL_SIZE^2 signed fixed-point pixels is
// multiplied slot-by-slot with the weight vector. The products are rescaled
// by FRAC_BIT (an arithmetic shift, so it rounds toward -inf) and summed with
// the bias. The window is the only state. The arithmetic is combinational,
// so bias and weight changes show up on add_result in the same cycle.
//
// Optional feature macro: DATAPATH_SATURATE_EN
//   - Defined: the accumulator is clamped to the signed DATA_WIDTH range.
//   - Undefined (default): the accumulator is wrapped to DATA_WIDTH bits.
// Results that are already in range are the same in both builds.

module conv_datapath #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 5
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            write,
    input  logic [DATA_WIDTH-1:0]                           bias,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   weights,
    input  logic [DATA_WIDTH-1:0]                           pixel_input,
    output logic [DATA_WIDTH-1:0]                           add_result
);

    localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PROD_W = 2 * DATA_WIDTH;
    // Wide enough for the bias plus N rescaled products, so the sum never overflows.
    localparam int ACC_W  = DATA_WIDTH + FRAC_BIT + $clog2(N) + 1;

`ifdef DATAPATH_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

    logic signed [DATA_WIDTH-1:0] win_q [N];
    logic signed [DATA_WIDTH-1:0] win_d [N];
    logic signed [ACC_W-1:0]      acc_s;

    // Next window: shift a new pixel into slot 0 on write, otherwise hold.
    always_comb begin
        win_d = win_q;
        if (write) begin
            win_d[0] = pixel_input;
            for (int i = 1; i < N; i++) begin
                win_d[i] = win_q[i-1];
            end
        end else begin
            win_d = win_q;
        end
    end

    // Window register. Reset clears every slot and takes priority over write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Multiply-accumulate: bias plus the sum of rescaled products.
    always_comb begin
        acc_s = ACC_W'($signed(bias));
        for (int i = 0; i < N; i++) begin
            logic signed [DATA_WIDTH-1:0] wgt_v;
            logic signed [PROD_W-1:0]     prod_v;
            logic signed [PROD_W-1:0]     scaled_v;
            wgt_v    = weights[i*DATA_WIDTH +: DATA_WIDTH];
            prod_v   = PROD_W'(win_q[i]) * PROD_W'(wgt_v);
            scaled_v = prod_v >>> FRAC_BIT;
            acc_s    = acc_s + ACC_W'(scaled_v);
        end
    end

    // Reduce the accumulator to the output width (clamp or wrap).
    always_comb begin
        add_result = '0;
`ifdef DATAPATH_SATURATE_EN
        if (acc_s > SAT_MAX) begin
            add_result = DATA_WIDTH'(SAT_MAX);
        end else if (acc_s < SAT_MIN) begin
            add_result = DATA_WIDTH'(SAT_MIN);
        end else begin
            add_result = DATA_WIDTH'(acc_s);
        end
`else
        add_result = DATA_WIDTH'(acc_s);
`endif
    end

endmodule

// File: tb/tb_conv_datapath.sv
// Testbench for conv_datapath.
// The stimulus pushes the expected results into a queue, and a monitor
// checks them on the falling clock edge. Expected values are either taken
// directly from the worked examples or come from a reference model. The
// model keeps the history of written pixels, newest first, and treats any
// missing slot as zero. It uses floor-division arithmetic on wide integers.

module tb_conv_datapath;

    localparam int DW = 16;
    localparam int KS = 5;
    localparam int N  = KS * KS;
    localparam longint SCALE = 256;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            write = 1'b0;
    logic [DW-1:0]   bias = 16'h0000;
    logic [N*DW-1:0] weights = '0;
    logic [DW-1:0]   pixel_input = 16'h0000;
    logic [DW-1:0]   add_result;

    int              hist[$];
    logic [DW-1:0]   exp_q[$];
    string           name_q[$];
    int              pass_cnt = 0;
    int              total_cnt = 0;

    conv_datapath #(.DATA_WIDTH(DW), .FRAC_BIT(8), .KERNEL_SIZE(KS)) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .bias       (bias),
        .weights    (weights),
        .pixel_input(pixel_input),
        .add_result (add_result)
    );

    always #5 clk = ~clk;

    // Reference model: weighted sum of the pixel history, floor-scaled.
    function automatic logic [DW-1:0] model_out();
        logic signed [DW-1:0] b16;
        logic signed [DW-1:0] w16;
        longint acc, px, p, q;
        logic [63:0] acc_bits;
        b16 = bias;
        acc = longint'(b16);
        for (int i = 0; i < N; i++) begin
            px  = (i < hist.size()) ? longint'(hist[i]) : 64'sd0;
            w16 = weights[i*DW +: DW];
            p   = px * longint'(w16);
            q   = p / SCALE;
            if (p < 0 && (p % SCALE) != 0) q = q - 1;
            acc = acc + q;
        end
`ifdef DATAPATH_SATURATE_EN
        if (acc > 64'sd32767) acc = 64'sd32767;
        else if (acc < -64'sd32768) acc = -64'sd32768;
`endif
        acc_bits = acc;
        return acc_bits[DW-1:0];
    endfunction

    // One clock edge with the given controls, then update the model.
    task automatic step(input logic rst, input logic wr, input logic [DW-1:0] pix);
        logic signed [DW-1:0] s;
        reset = rst; write = wr; pixel_input = pix;
        @(posedge clk); #1;
        if (rst) begin
            hist.delete();
        end else if (wr) begin
            s = pix;
            hist.push_front(int'(s));
            if (hist.size() > N) void'(hist.pop_back());
        end
        reset = 1'b0; write = 1'b0;
    endtask

    // Queue an expectation and let the monitor consume it on the next falling edge.
    task automatic expect_val(input logic [DW-1:0] v, input string nm);
        exp_q.push_back(v);
        name_q.push_back(nm);
        @(negedge clk); #1;
    endtask

    task automatic set_all_weights(input logic [DW-1:0] w);
        for (int i = 0; i < N; i++) weights[i*DW +: DW] = w;
    endtask

    task automatic set_one_weight(input int k, input logic [DW-1:0] w);
        weights = '0;
        weights[k*DW +: DW] = w;
    endtask

    // Monitor: compare add_result against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [DW-1:0] e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total_cnt++;
            if (add_result !== e)
                $display("FAIL %s: add_result=%h expected=%h", nm, add_result, e);
            else
                pass_cnt++;
        end
    end

    initial begin
        @(negedge clk); #1;

        // 1: reset state and bias pass-through
        step(1'b1, 1'b0, 16'h0000);
        expect_val(16'h0000, "t1_reset");
        bias = 16'h0100;
        expect_val(16'h0100, "t1_bias");

        // 2: full window of 2.0 with unit weights
        bias = 16'h0000;
        set_all_weights(16'h0100);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 16'h0200);
        expect_val(16'h3200, "t2_full");
        bias = 16'hFF00;
        expect_val(16'h3100, "t2_negbias");

        // 3: shift order
        bias = 16'h0000;
        step(1'b1, 1'b0, 16'h0000);
        set_one_weight(0, 16'h0100);
        step(1'b0, 1'b1, 16'h0300);
        expect_val(16'h0300, "t3_first");
        step(1'b0, 1'b1, 16'h0500);
        expect_val(16'h0500, "t3_slot0");
        set_one_weight(1, 16'h0100);
        expect_val(16'h0300, "t3_slot1");

        // 4: hold with write low and pixel_input toggling
        set_all_weights(16'h0100);
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 16'h0200);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, (i % 2 == 0) ? 16'h7FFF : 16'h8001);
            expect_val(16'h3200, "t4_hold");
        end

        // 5: extreme operands (clamped or wrapped by build)
        set_all_weights(16'h7FFF);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 16'h7FFF);
        expect_val(model_out(), "t5_posmax");
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 16'h8000);
        expect_val(model_out(), "t5_negmax");
        set_one_weight(0, 16'h8000);
        expect_val(model_out(), "t5_minxmin");

        // 6: reset together with write mid-stream
        bias = 16'h0123;
        set_all_weights(16'h0100);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'h0440);
        step(1'b1, 1'b1, 16'h0700);
        expect_val(16'h0123, "t6_reset_wr");
        for (int k = 0; k < N; k++) begin
            set_one_weight(k, 16'h0100);
            expect_val(16'h0123, "t6_probe");
        end

        // 7: randomized traffic against the model
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(7) == 0) begin
                for (int i = 0; i < N; i++) weights[i*DW +: DW] = 16'($urandom);
                bias = 16'($urandom);
            end
            step(($urandom_range(39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
                 16'($urandom));
            expect_val(model_out(), "t7_random");
        end

        // Drain, with a bound
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
